led_blink_driver: RTL

LED_BLINK_DRIVER -- requirements
Module: led_blink_driver

---
 rtl/led_drv_pkg.sv | 53 +++++
 rtl/led_pwm_dimmer.sv | 43 ++++
 rtl/led_blink_driver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/led_drv_pkg.sv
// ---------------------------------------------------------------------------
// led_drv_pkg
// Shared definitions for the LED blink driver. It holds the command codes
// presented on i_cmd, the mode codes reported on o_mode, and the FSM state
// enum.
//
// It also provides two helpers that map an FSM state to its reported mode
// and to its "lit" condition. Both the top level and the optional
// dimmer path use them, so the decode lives in one place.
// ---------------------------------------------------------------------------
package led_drv_pkg;

    // Command codes carried on i_cmd
    typedef enum logic [1:0] {
        CMD_OFF    = 2'b00,
        CMD_ON     = 2'b01,
        CMD_BLINK  = 2'b10,
        CMD_TOGGLE = 2'b11
    } cmd_e;

    // Mode codes reported on o_mode
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    // Width of the free-running PWM counter (16-cycle dimming period)
    localparam int PWM_BITS = 4;

    typedef enum logic [1:0] {
        S_OFF      = 2'b00,
        S_ON       = 2'b01,
        S_BLINK_HI = 2'b10,
        S_BLINK_LO = 2'b11
    } state_e;

    // Both blink phases report the same mode
    function automatic logic [1:0] state_mode(input state_e s);
        logic [1:0] m;
        case (s)
            S_ON:       m = MODE_ON;
            S_BLINK_HI: m = MODE_BLINK;
            S_BLINK_LO: m = MODE_BLINK;
            default:    m = MODE_OFF;
        endcase
        return m;
    endfunction

    // The LED is lit in the steady-on state and in the high blink phase
    function automatic logic state_lit(input state_e s);
        return (s == S_ON) || (s == S_BLINK_HI);
    endfunction

endpackage

// File: rtl/led_pwm_dimmer.sv
// ---------------------------------------------------------------------------
// led_pwm_dimmer
// Brightness gate for the LED. A 16-cycle free-running counter is compared
// against i_duty. The registered output is high only while the LED should
// be lit and the counter is below the duty value. A duty of 0 keeps the LED
// dark; a duty of 15 lights it for 15 of every 16 cycles.
//
// i_duty is sampled every cycle and is not latched.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset (clears counter and output)
//   i_duty  in   [3:0] brightness
//   i_lit   in   LED should be lit (from the driver FSM)
//   o_led   out  registered, dimmed LED drive
// ---------------------------------------------------------------------------
module led_pwm_dimmer
    import led_drv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic                i_lit,
    output logic                o_led
);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_led     <= 1'b0;
        end else begin
            // Wraps naturally at 16
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_led     <= i_lit && (r_pwm_cnt < i_duty);
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_blink_driver.sv
// ---------------------------------------------------------------------------
// led_blink_driver
// A command-driven LED controller with OFF, ON, BLINK and TOGGLE commands.
// Commands arrive as one-cycle strobes and are never back-pressured.
//
// In blink mode a half-period counter runs 0..BLINK_HALF-1. On the terminal
// count the FSM flips between the high and low phases. A command arriving
// on the terminal-count cycle takes priority over the phase flip.
//
// o_led and o_mode are registered from the current state. A command
// sampled at edge N therefore appears on the outputs after edge N+1.
//
// Optional feature (macro LED_BLINK_DRIVER_DIM_EN):
//   Adds input i_duty[3:0] and routes the lit condition through
//   led_pwm_dimmer for 16-step brightness control. Without the macro,
//   lit states drive o_led high continuously.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   i_cmd_valid  in   one-cycle command strobe
//   i_cmd        in   [1:0] 00 OFF, 01 ON, 10 BLINK, 11 TOGGLE
//   i_duty       in   [3:0] brightness (only with LED_BLINK_DRIVER_DIM_EN)
//   o_led        out  registered LED drive, 1 = lit
//   o_mode       out  [1:0] 00 OFF, 01 ON, 10 BLINK
//
// Parameters:
//   BLINK_HALF   clk cycles per blink half-period (min 2)
// ---------------------------------------------------------------------------
module led_blink_driver #(
    parameter int BLINK_HALF = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd,
`ifdef LED_BLINK_DRIVER_DIM_EN
    input  logic [3:0] i_duty,
`endif
    output logic       o_led,
    output logic [1:0] o_mode
);

    import led_drv_pkg::*;

    localparam int            CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] TC = CW'(BLINK_HALF - 1);

    state_e        r_state;
    state_e        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    r_mode;
    logic          w_lit;

    // State, counter and mode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_mode  <= MODE_OFF;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_mode  <= state_mode(r_state);
        end
    end

    // Next-state logic. The phase progression is computed first. A valid
    // command then overrides it, which gives commands priority over a
    // coincident terminal count. The counter defaults to 0, so it holds at
    // 0 outside the blink states and clears on every command transition.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;

        case (r_state)
            S_BLINK_HI, S_BLINK_LO: begin
                if (r_cnt == TC) begin
                    w_state_next = (r_state == S_BLINK_HI) ? S_BLINK_LO : S_BLINK_HI;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: ;
        endcase

        if (i_cmd_valid) begin
            case (i_cmd)
                CMD_OFF: begin
                    w_state_next = S_OFF;
                    w_cnt_next   = '0;
                end
                CMD_ON: begin
                    w_state_next = S_ON;
                    w_cnt_next   = '0;
                end
                CMD_BLINK: begin
                    // While already blinking, leave phase and counter alone
                    if (r_state == S_OFF || r_state == S_ON) begin
                        w_state_next = S_BLINK_HI;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    // CMD_TOGGLE: only S_OFF turns on; ON and both blink
                    // phases turn off
                    w_state_next = (r_state == S_OFF) ? S_ON : S_OFF;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign w_lit  = state_lit(r_state);
    assign o_mode = r_mode;

`ifdef LED_BLINK_DRIVER_DIM_EN
    // The dimmer's output register doubles as the LED output register,
    // so latency is unchanged
    led_pwm_dimmer u_pwm (
        .clk    (clk),
        .rst    (rst),
        .i_duty (i_duty),
        .i_lit  (w_lit),
        .o_led  (o_led)
    );
`else
    logic r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_lit;
        end
    end

    assign o_led = r_led;
`endif

endmodule
